// File: rtl/dbg_arb_pkg.sv
// Shared types for the two-master debug/core bus arbiter.
package dbg_arb_pkg;

    typedef enum logic {
        MST_CORE = 1'b0,
        MST_DBG  = 1'b1
    } mst_id_e;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;

    // Request payload at the default bus widths; the top builds the same shape
    // from its own ADDR_W/DATA_W parameters.
    typedef struct packed {
        logic                    we;
        logic [BUS_DATA_W/8-1:0] be;
        logic [BUS_ADDR_W-1:0]   addr;
        logic [BUS_DATA_W-1:0]   wdata;
    } bus_req_t;

endpackage

// File: rtl/dbg_arb_id_fifo.sv
// In-order FIFO of master IDs for the outstanding slave transactions.
module dbg_arb_id_fifo
    import dbg_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  mst_id_e din_i,
    output mst_id_e dout_o,
    output logic    full_o,
    output logic    empty_o
);

    logic do_push;
    logic do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    if (DEPTH == 1) begin : g_flag
        // With one slot the pointers collapse into a single occupied flag.
        mst_id_e data_q;
        logic    full_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_q <= MST_CORE;
                full_q <= 1'b0;
            end else if (do_push) begin
                data_q <= din_i;
                full_q <= 1'b1;
            end else if (do_pop) begin
                full_q <= 1'b0;
            end
        end

        assign dout_o  = data_q;
        assign full_o  = full_q;
        assign empty_o = ~full_q;
    end else begin : g_ring
        localparam int unsigned PW = $clog2(DEPTH);
        localparam int unsigned CW = PW + 1;

        mst_id_e         mem_q [DEPTH];
        logic [PW-1:0]   wptr_q;
        logic [PW-1:0]   rptr_q;
        logic [CW-1:0]   cnt_q;

        always_ff @(posedge clk_i) begin
            if (do_push) begin
                mem_q[wptr_q] <= din_i;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (do_push) wptr_q <= wptr_q + PW'(1);
                if (do_pop)  rptr_q <= rptr_q + PW'(1);
                case ({do_push, do_pop})
                    2'b10:   cnt_q <= cnt_q + CW'(1);
                    2'b01:   cnt_q <= cnt_q - CW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        assign dout_o  = mem_q[rptr_q];
        assign full_o  = (cnt_q == CW'(DEPTH));
        assign empty_o = (cnt_q == '0);
    end

endmodule

// File: rtl/dbg_bus_arbiter.sv
// Merges core LSU and debug system-bus traffic onto one req/gnt/rvalid slave,
// steering in-order responses back through an ID FIFO.
module dbg_bus_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned DBG_PRIO  = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_err_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_err_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_gnt_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic                s_err_i,
    output logic                spurious_o
);

    typedef struct packed {
        logic                we;
        logic [DATA_W/8-1:0] be;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } req_t;

    arb_state_e state_q;
    mst_id_e    last_q;
    mst_id_e    lock_id_q;
    logic       spurious_q;

    mst_id_e win;
    mst_id_e sel;
    mst_id_e head_id;
    logic    fifo_full;
    logic    fifo_empty;
    logic    grant;
    logic    pop;
    req_t    m0_pl;
    req_t    m1_pl;
    req_t    s_pl;

    always_comb begin
        win = MST_CORE;
        if (m0_req_i && m1_req_i) begin
            win = ((DBG_PRIO != 0) || (last_q == MST_CORE)) ? MST_DBG : MST_CORE;
        end else if (m1_req_i) begin
            win = MST_DBG;
        end
    end

    assign sel = (state_q == LOCK) ? lock_id_q : win;

    // A full FIFO masks the request from registered state only, so s_rvalid_i
    // never reaches s_req_o combinationally.
    assign s_req_o = ((state_q == LOCK) | m0_req_i | m1_req_i) & ~fifo_full & ~rst_i;
    assign grant   = s_req_o & s_gnt_i;

    assign m0_pl = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
    assign m1_pl = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};
    assign s_pl  = (sel == MST_DBG) ? m1_pl : m0_pl;

    assign s_we_o    = s_pl.we;
    assign s_be_o    = s_pl.be;
    assign s_addr_o  = s_pl.addr;
    assign s_wdata_o = s_pl.wdata;

    assign m0_gnt_o = grant & (sel == MST_CORE);
    assign m1_gnt_o = grant & (sel == MST_DBG);

    assign pop         = s_rvalid_i & ~fifo_empty & ~rst_i;
    assign m0_rvalid_o = pop & (head_id == MST_CORE);
    assign m1_rvalid_o = pop & (head_id == MST_DBG);
    assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;
    assign m0_err_o    = m0_rvalid_o & s_err_i;
    assign m1_err_o    = m1_rvalid_o & s_err_i;
    assign spurious_o  = spurious_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= MST_DBG;
            lock_id_q  <= MST_CORE;
            spurious_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_req_o && !s_gnt_i) begin
                        state_q   <= LOCK;
                        lock_id_q <= win;
                    end
                end
                LOCK: begin
                    if (grant) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (grant) last_q <= sel;
            if (s_rvalid_i && fifo_empty) spurious_q <= 1'b1;
        end
    end

    dbg_arb_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .pop_i   (pop),
        .din_i   (sel),
        .dout_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// Directed bench: a round-robin and a debug-priority arbiter share one stimulus stream.
module tb_dbg_bus_arbiter;

    localparam logic [31:0] A0 = 32'h8000_0010;
    localparam logic [31:0] A1 = 32'h1000_0004;
    localparam logic [31:0] W0 = 32'hDEAD_BEEF;
    localparam logic [31:0] W1 = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        s_gnt = 1'b0, s_rvalid = 1'b0, s_err = 1'b0;
    logic [31:0] s_rdata = '0;

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, spurious;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;

    logic        p_m0_gnt, p_m0_rvalid, p_m0_err, p_m1_gnt, p_m1_rvalid, p_m1_err;
    logic [31:0] p_m0_rdata, p_m1_rdata;
    logic        p_s_req, p_s_we, p_spurious;
    logic [3:0]  p_s_be;
    logic [31:0] p_s_addr, p_s_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbg_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .DBG_PRIO(0)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(1'b1), .m0_be_i(4'hF), .m0_addr_i(A0), .m0_wdata_i(W0),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(1'b0), .m1_be_i(4'h3), .m1_addr_i(A1), .m1_wdata_i(W1),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err),
        .spurious_o(spurious)
    );

    dbg_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .DBG_PRIO(1)) u_pr (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(1'b1), .m0_be_i(4'hF), .m0_addr_i(A0), .m0_wdata_i(W0),
        .m0_gnt_o(p_m0_gnt), .m0_rvalid_o(p_m0_rvalid), .m0_rdata_o(p_m0_rdata), .m0_err_o(p_m0_err),
        .m1_req_i(m1_req), .m1_we_i(1'b0), .m1_be_i(4'h3), .m1_addr_i(A1), .m1_wdata_i(W1),
        .m1_gnt_o(p_m1_gnt), .m1_rvalid_o(p_m1_rvalid), .m1_rdata_o(p_m1_rdata), .m1_err_o(p_m1_err),
        .s_req_o(p_s_req), .s_we_o(p_s_we), .s_be_o(p_s_be), .s_addr_o(p_s_addr), .s_wdata_o(p_s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err),
        .spurious_o(p_spurious)
    );

    typedef struct packed {
        logic        m0, m1, g, rv;
        logic [31:0] rd;
        logic        er;
        logic        sreq;
        logic [31:0] addr;
        logic        g0, g1, rv0, rv1, pg0, pg1;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic m0, m1, g, rv, input logic [31:0] rd, input logic er,
                       input logic sreq, input logic [31:0] addr,
                       input logic g0, g1, rv0, rv1, pg0, pg1);
        vec_t v;
        v.m0 = m0; v.m1 = m1; v.g = g; v.rv = rv; v.rd = rd; v.er = er;
        v.sreq = sreq; v.addr = addr;
        v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1; v.pg0 = pg0; v.pg1 = pg1;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, m0, m1, g, rv, input logic [31:0] rd, input logic er);
        @(negedge clk);
        rst = r; m0_req = m0; m1_req = m1; s_gnt = g;
        s_rvalid = rv; s_rdata = rd; s_err = er;
        #1;
    endtask

    // Slave-side payload expected for whichever master address is on the bus.
    task automatic chk_payload(input string tag, input logic [31:0] addr);
        chk({tag, ".addr"},  s_addr,  addr);
        chk({tag, ".wdata"}, s_wdata, (addr == A0) ? W0 : W1);
        chk({tag, ".we"},    {31'd0, s_we}, (addr == A0) ? 32'd1 : 32'd0);
        chk({tag, ".be"},    {28'd0, s_be}, (addr == A0) ? 32'hF : 32'h3);
    endtask

    initial begin
        // Reset with both masters requesting: slave request and grants held low.
        cyc(1, 1, 1, 1, 0, '0, 0);
        cyc(1, 1, 1, 1, 0, '0, 0);
        chk("rst.s_req",    {31'd0, s_req},    32'd0);
        chk("rst.p_s_req",  {31'd0, p_s_req},  32'd0);
        chk("rst.gnt",      {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst.spurious", {31'd0, spurious}, 32'd0);

        // m0 single write, response 2 cycles later.
        add(1,0,1,0, 32'h0,          0, 1, A0, 1,0,0,0, 1,0);
        add(0,0,0,0, 32'h0,          0, 0, A0, 0,0,0,0, 0,0);
        add(0,0,0,1, 32'h1111_0001,  0, 0, A0, 0,0,1,0, 0,0);
        // Both requesting with gnt tied high: round robin alternates, prio stays on m1.
        add(1,1,1,0, 32'h0,          0, 1, A1, 0,1,0,0, 0,1);
        add(1,1,1,1, 32'h2222_0002,  0, 1, A0, 1,0,0,1, 0,1);
        add(1,1,1,1, 32'h3333_0003,  0, 1, A1, 0,1,1,0, 0,1);
        add(1,1,1,1, 32'h4444_0004,  1, 1, A0, 1,0,0,1, 0,1);
        add(0,0,0,1, 32'h5555_0005,  0, 0, A0, 0,0,1,0, 0,0);
        // Fill the FIFO, then s_req drops until the cycle after a pop.
        add(1,0,1,0, 32'h0,          0, 1, A0, 1,0,0,0, 1,0);
        add(1,0,1,0, 32'h0,          0, 1, A0, 1,0,0,0, 1,0);
        add(1,0,1,0, 32'h0,          0, 0, A0, 0,0,0,0, 0,0);
        add(1,0,1,1, 32'h6666_0006,  0, 0, A0, 0,0,1,0, 0,0);
        add(1,0,1,0, 32'h0,          0, 1, A0, 1,0,0,0, 1,0);
        add(0,0,0,1, 32'h7777_0007,  0, 0, A0, 0,0,1,0, 0,0);
        add(0,0,0,1, 32'h8888_0008,  1, 0, A0, 0,0,1,0, 0,0);
        // Another round-robin burst against the fixed-priority instance.
        add(1,1,1,0, 32'h0,          0, 1, A1, 0,1,0,0, 0,1);
        add(1,1,1,1, 32'h9999_0009,  0, 1, A0, 1,0,0,1, 0,1);
        add(1,1,1,1, 32'hAAAA_000A,  0, 1, A1, 0,1,1,0, 0,1);
        add(0,0,0,1, 32'hBBBB_000B,  0, 0, A0, 0,0,0,1, 0,0);

        for (int i = 0; i < vt.size(); i++) begin
            vec_t v;
            string t;
            v = vt[i];
            t = $sformatf("v%0d", i);
            cyc(0, v.m0, v.m1, v.g, v.rv, v.rd, v.er);
            chk({t, ".s_req"},   {31'd0, s_req},     {31'd0, v.sreq});
            chk({t, ".p_s_req"}, {31'd0, p_s_req},   {31'd0, v.sreq});
            chk({t, ".m0_gnt"},  {31'd0, m0_gnt},    {31'd0, v.g0});
            chk({t, ".m1_gnt"},  {31'd0, m1_gnt},    {31'd0, v.g1});
            chk({t, ".p_m0_gnt"},{31'd0, p_m0_gnt},  {31'd0, v.pg0});
            chk({t, ".p_m1_gnt"},{31'd0, p_m1_gnt},  {31'd0, v.pg1});
            chk({t, ".m0_rv"},   {31'd0, m0_rvalid}, {31'd0, v.rv0});
            chk({t, ".m1_rv"},   {31'd0, m1_rvalid}, {31'd0, v.rv1});
            chk({t, ".m0_rd"},   m0_rdata, v.rv0 ? v.rd : 32'd0);
            chk({t, ".m1_rd"},   m1_rdata, v.rv1 ? v.rd : 32'd0);
            chk({t, ".m0_err"},  {31'd0, m0_err},    {31'd0, v.rv0 & v.er});
            chk({t, ".m1_err"},  {31'd0, m1_err},    {31'd0, v.rv1 & v.er});
            if (v.sreq) chk_payload(t, v.addr);
        end

        // Slave stalls while m0 is pending; m1's request must not disturb the lock,
        // not even on the debug-priority instance.
        for (int c = 0; c < 3; c++) begin
            cyc(0, 1, (c > 0), 0, 0, '0, 0);
            chk($sformatf("lock%0d.s_req", c), {31'd0, s_req}, 32'd1);
            chk_payload($sformatf("lock%0d", c), A0);
            chk($sformatf("lock%0d.p_addr", c), p_s_addr, A0);
            chk($sformatf("lock%0d.gnt", c), {28'd0, p_m1_gnt, p_m0_gnt, m1_gnt, m0_gnt}, 32'd0);
        end
        cyc(0, 1, 1, 1, 0, '0, 0);
        chk("lock_rel.gnt", {28'd0, p_m1_gnt, p_m0_gnt, m1_gnt, m0_gnt}, 32'b0101);
        cyc(0, 0, 1, 1, 0, '0, 0);
        chk("lock_m1.gnt",  {28'd0, p_m1_gnt, p_m0_gnt, m1_gnt, m0_gnt}, 32'b1010);
        chk_payload("lock_m1", A1);
        cyc(0, 0, 0, 0, 1, 32'hC0C0_0001, 0);
        chk("lock_rsp0.rd", m0_rdata, 32'hC0C0_0001);
        chk("lock_rsp0.m1rv", {31'd0, m1_rvalid}, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'hC0C0_0002, 0);
        chk("lock_rsp1.rd", m1_rdata, 32'hC0C0_0002);
        chk("lock_rsp1.m0rv", {31'd0, m0_rvalid}, 32'd0);

        // Reset with one transaction outstanding; the late response is spurious.
        cyc(0, 1, 0, 1, 0, '0, 0);
        chk("mid.m0_gnt", {31'd0, m0_gnt}, 32'd1);
        cyc(1, 1, 0, 1, 1, 32'h5A5A_5A5A, 0);
        chk("mid_rst.s_req", {31'd0, s_req}, 32'd0);
        chk("mid_rst.gnt_rv", {28'd0, m1_rvalid, m0_rvalid, m1_gnt, m0_gnt}, 32'd0);
        cyc(0, 0, 0, 0, 0, '0, 0);
        chk("post_rst.spurious", {31'd0, spurious}, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'h1234_5678, 0);
        chk("late.rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("late.rd", m0_rdata | m1_rdata, 32'd0);
        cyc(0, 0, 0, 0, 0, '0, 0);
        chk("late.spurious",   {31'd0, spurious},   32'd1);
        chk("late.p_spurious", {31'd0, p_spurious}, 32'd1);
        cyc(0, 1, 0, 1, 0, '0, 0);
        chk("after.m0_gnt", {31'd0, m0_gnt}, 32'd1);
        cyc(0, 0, 0, 0, 1, 32'hFACE_0001, 0);
        chk("after.m0_rd", m0_rdata, 32'hFACE_0001);
        chk("sticky.spurious", {31'd0, spurious}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
